// File: rtl/cpu_pkg.sv
// Shared definitions for the core pipeline control blocks.
//  - FWD_*  : ALU operand-mux select codes driven by the forwarding unit
//  - HC_*   : hazard_ctrl sequencer state codes (2-bit)
package cpu_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;  // use register-file read data
    localparam logic [1:0] FWD_WB   = 2'b01;  // use WB-stage write data
    localparam logic [1:0] FWD_MEM  = 2'b10;  // use MEM-stage ALU result

    localparam logic [1:0] HC_RUN    = 2'b00;
    localparam logic [1:0] HC_DRAIN  = 2'b01;
    localparam logic [1:0] HC_HALTED = 2'b10;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX-stage ALU source.
// Ports:
//   src              in   REG_W  source specifier of the EX instruction
//   ex_mem_rd        in   REG_W  destination in MEM
//   ex_mem_reg_write in   1      MEM instruction writes the register file
//   mem_wb_rd        in   REG_W  destination in WB
//   mem_wb_reg_write in   1      WB instruction writes the register file
//   fwd              out  2      FWD_MEM / FWD_WB / FWD_NONE
module fwd_select
    import cpu_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic             ex_mem_reg_write,
    input  logic [REG_W-1:0] mem_wb_rd,
    input  logic             mem_wb_reg_write,
    output logic [1:0]       fwd
);

    logic mem_hit;
    logic wb_hit;

    // R0 is hardwired zero, so a write to it must never be forwarded.
    assign mem_hit = ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == src);
    assign wb_hit  = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == src);

    // MEM holds the younger result, so it wins over WB.
    assign fwd = mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_NONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: EX operand forwarding, load-use
// stall/bubble insertion, IF/ID flush on taken branch, HLT drain-and-park,
// and a saturating count of load-use bubbles.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   IF_ID_rs/rt/uses_rt/halt     decode-stage operand info and HLT flag
//   branch_taken                 ID branch resolved taken
//   ID_EX_rs/rt/rd/MemRead       execute-stage specifiers, load flag
//   EX_MEM_rd/RegWrite           MEM-stage writeback info
//   MEM_WB_rd/RegWrite           WB-stage writeback info
//   ForwardA/ForwardB            ALU operand mux selects
//   stall_PC/stall_IFID          hold PC / IF/ID
//   bubble_IDEX                  load NOP into ID/EX
//   flush_IFID                   replace IF/ID with NOP
//   halted                       core parked until reset
//   bubble_cnt                   saturating load-use bubble count
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_W        = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] IF_ID_rs,
    input  logic [REG_W-1:0] IF_ID_rt,
    input  logic             IF_ID_uses_rt,
    input  logic             IF_ID_halt,
    input  logic             branch_taken,
    input  logic [REG_W-1:0] ID_EX_rs,
    input  logic [REG_W-1:0] ID_EX_rt,
    input  logic [REG_W-1:0] ID_EX_rd,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] EX_MEM_rd,
    input  logic             EX_MEM_RegWrite,
    input  logic [REG_W-1:0] MEM_WB_rd,
    input  logic             MEM_WB_RegWrite,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             stall_PC,
    output logic             stall_IFID,
    output logic             bubble_IDEX,
    output logic             flush_IFID,
    output logic             halted,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [1:0]    state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic [1:0]    fwd_a, fwd_b;
    logic          lu;
    logic          cnt_inc;

    fwd_select #(.REG_W(REG_W)) u_fwd_a (
        .src              (ID_EX_rs),
        .ex_mem_rd        (EX_MEM_rd),
        .ex_mem_reg_write (EX_MEM_RegWrite),
        .mem_wb_rd        (MEM_WB_rd),
        .mem_wb_reg_write (MEM_WB_RegWrite),
        .fwd              (fwd_a)
    );

    fwd_select #(.REG_W(REG_W)) u_fwd_b (
        .src              (ID_EX_rt),
        .ex_mem_rd        (EX_MEM_rd),
        .ex_mem_reg_write (EX_MEM_RegWrite),
        .mem_wb_rd        (MEM_WB_rd),
        .mem_wb_reg_write (MEM_WB_RegWrite),
        .fwd              (fwd_b)
    );

    // Load in EX whose result is needed by the instruction in ID.
    assign lu = ID_EX_MemRead && (ID_EX_rd != '0) &&
                ((ID_EX_rd == IF_ID_rs) || (IF_ID_uses_rt && (ID_EX_rd == IF_ID_rt)));

    // Outputs are held low while reset is asserted, not just after the edge.
    assign ForwardA = (rst || state == HC_HALTED) ? FWD_NONE : fwd_a;
    assign ForwardB = (rst || state == HC_HALTED) ? FWD_NONE : fwd_b;

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        stall_PC      = 1'b0;
        stall_IFID    = 1'b0;
        bubble_IDEX   = 1'b0;
        flush_IFID    = 1'b0;
        halted        = 1'b0;
        cnt_inc       = 1'b0;
        if (!rst) begin
            case (state)
                HC_RUN: begin
                    // Stall takes precedence; a taken branch re-resolves
                    // next cycle once the dependency clears.
                    if (lu) begin
                        stall_PC    = 1'b1;
                        stall_IFID  = 1'b1;
                        bubble_IDEX = 1'b1;
                        cnt_inc     = 1'b1;
                    end else if (branch_taken) begin
                        flush_IFID = 1'b1;
                    end else if (IF_ID_halt) begin
                        stall_PC      = 1'b1;
                        stall_IFID    = 1'b1;
                        drain_cnt_nxt = DW'(DRAIN_CYCLES - 1);
                        state_nxt     = HC_DRAIN;
                    end
                end
                HC_DRAIN: begin
                    stall_PC    = 1'b1;
                    stall_IFID  = 1'b1;
                    bubble_IDEX = 1'b1;
                    if (drain_cnt == '0) state_nxt = HC_HALTED;
                    else                 drain_cnt_nxt = drain_cnt - DW'(1);
                end
                HC_HALTED: begin
                    stall_PC    = 1'b1;
                    stall_IFID  = 1'b1;
                    bubble_IDEX = 1'b1;
                    halted      = 1'b1;
                end
                default: state_nxt = HC_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HC_RUN;
            drain_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (cnt_inc && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. Stimulus is applied 1 ns after each
// rising edge; the reference model pushes the expected outputs for that
// cycle, and a monitor on the falling edge pops and compares. A second
// instance built with CNT_W=2 shares all inputs to exercise saturation.
module tb_hazard_ctrl;

    localparam int DRAIN = 3;

    typedef struct packed {
        logic [3:0] if_rs, if_rt;
        logic       uses_rt, halt, br;
        logic [3:0] ex_rs, ex_rt, ex_rd;
        logic       memrd;
        logic [3:0] mem_rd;
        logic       mem_rw;
        logic [3:0] wb_rd;
        logic       wb_rw;
    } stim_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       spc, sif, bub, fl, hlt;
        int         cnt, cnt2;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] IF_ID_rs = '0, IF_ID_rt = '0, ID_EX_rs = '0, ID_EX_rt = '0, ID_EX_rd = '0;
    logic [3:0] EX_MEM_rd = '0, MEM_WB_rd = '0;
    logic IF_ID_uses_rt = 0, IF_ID_halt = 0, branch_taken = 0, ID_EX_MemRead = 0;
    logic EX_MEM_RegWrite = 0, MEM_WB_RegWrite = 0;

    logic [1:0]  fa1, fb1, fa2, fb2;
    logic        spc1, sif1, bub1, fl1, hlt1, spc2, sif2, bub2, fl2, hlt2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    int checks = 0, errors = 0;
    exp_t sb[$];

    // reference model state
    int halt_age = -1;   // cycles since HLT was accepted; -1 when not halting
    int lu_count = 0;    // unbounded count of load-use stalls since reset

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(4), .DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rt(IF_ID_uses_rt),
        .IF_ID_halt(IF_ID_halt), .branch_taken(branch_taken),
        .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd), .ID_EX_MemRead(ID_EX_MemRead),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .MEM_WB_rd(MEM_WB_rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .ForwardA(fa1), .ForwardB(fb1), .stall_PC(spc1), .stall_IFID(sif1),
        .bubble_IDEX(bub1), .flush_IFID(fl1), .halted(hlt1), .bubble_cnt(cnt1)
    );

    hazard_ctrl #(.REG_W(4), .DRAIN_CYCLES(DRAIN), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rt(IF_ID_uses_rt),
        .IF_ID_halt(IF_ID_halt), .branch_taken(branch_taken),
        .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd), .ID_EX_MemRead(ID_EX_MemRead),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .MEM_WB_rd(MEM_WB_rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .ForwardA(fa2), .ForwardB(fb2), .stall_PC(spc2), .stall_IFID(sif2),
        .bubble_IDEX(bub2), .flush_IFID(fl2), .halted(hlt2), .bubble_cnt(cnt2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [3:0] src, input logic [3:0] mrd,
                                           input logic mrw, input logic [3:0] wrd, input logic wrw);
        if (mrw && mrd != 0 && mrd == src) return 2'b10;
        if (wrw && wrd != 0 && wrd == src) return 2'b01;
        return 2'b00;
    endfunction

    // Apply one cycle of inputs, push the expected outputs, advance the model.
    task automatic step(input stim_t s, input logic r);
        exp_t e;
        logic lu, in_halt, in_drain;
        @(posedge clk); #1;
        rst = r;
        IF_ID_rs = s.if_rs; IF_ID_rt = s.if_rt; IF_ID_uses_rt = s.uses_rt;
        IF_ID_halt = s.halt; branch_taken = s.br;
        ID_EX_rs = s.ex_rs; ID_EX_rt = s.ex_rt; ID_EX_rd = s.ex_rd; ID_EX_MemRead = s.memrd;
        EX_MEM_rd = s.mem_rd; EX_MEM_RegWrite = s.mem_rw;
        MEM_WB_rd = s.wb_rd; MEM_WB_RegWrite = s.wb_rw;
        e = '0;
        if (r) begin
            halt_age = -1;
            lu_count = 0;
        end else begin
            in_halt  = halt_age > DRAIN;
            in_drain = halt_age >= 1 && !in_halt;
            lu = s.memrd && s.ex_rd != 0 &&
                 (s.ex_rd == s.if_rs || (s.uses_rt && s.ex_rd == s.if_rt));
            e.cnt  = (lu_count > 65535) ? 65535 : lu_count;
            e.cnt2 = (lu_count > 3) ? 3 : lu_count;
            if (!in_halt) begin
                e.fa = fwd_ref(s.ex_rs, s.mem_rd, s.mem_rw, s.wb_rd, s.wb_rw);
                e.fb = fwd_ref(s.ex_rt, s.mem_rd, s.mem_rw, s.wb_rd, s.wb_rw);
            end
            if (halt_age >= 1 && halt_age < 1000) halt_age++;
            if (in_halt) begin
                e.spc = 1; e.sif = 1; e.bub = 1; e.hlt = 1;
            end else if (in_drain) begin
                e.spc = 1; e.sif = 1; e.bub = 1;
            end else if (lu) begin
                e.spc = 1; e.sif = 1; e.bub = 1;
                lu_count++;
            end else if (s.br) begin
                e.fl = 1;
            end else if (s.halt) begin
                e.spc = 1; e.sif = 1;
                halt_age = 1;
            end
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ForwardA",    int'(fa1),  int'(e.fa));
            chk("ForwardB",    int'(fb1),  int'(e.fb));
            chk("stall_PC",    int'(spc1), int'(e.spc));
            chk("stall_IFID",  int'(sif1), int'(e.sif));
            chk("bubble_IDEX", int'(bub1), int'(e.bub));
            chk("flush_IFID",  int'(fl1),  int'(e.fl));
            chk("halted",      int'(hlt1), int'(e.hlt));
            chk("bubble_cnt",  int'(cnt1), e.cnt);
            chk("w2_fwd",      int'({fa2, fb2}), int'({e.fa, e.fb}));
            chk("w2_ctl",      int'({spc2, sif2, bub2, fl2, hlt2}),
                               int'({e.spc, e.sif, e.bub, e.fl, e.hlt}));
            chk("w2_bubble_cnt", int'(cnt2), e.cnt2);
        end
    end

    initial begin
        stim_t s, lus, z;
        z = '0;
        // reset state
        step(z, 1); #1;
        chk("rst_outputs", int'({fa1, fb1, spc1, sif1, bub1, fl1, hlt1}), 0);
        chk("rst_cnt", int'(cnt1), 0);
        step(z, 1);

        // forwarding priority and R0
        s = z; s.ex_rs = 3; s.mem_rd = 3; s.mem_rw = 1; s.wb_rd = 3; s.wb_rw = 1;
        step(s, 0); #1; chk("t1_fwd_mem", int'(fa1), 2);
        s.mem_rw = 0;
        step(s, 0); #1; chk("t1_fwd_wb", int'(fa1), 1);
        s.mem_rw = 1; s.mem_rd = 0; s.wb_rd = 0;
        step(s, 0); #1; chk("t1_fwd_r0", int'(fa1), 0);

        // single load-use bubble
        lus = z; lus.memrd = 1; lus.ex_rd = 5; lus.if_rt = 5; lus.uses_rt = 1;
        step(lus, 0); #1; chk("t2_stall", int'({spc1, sif1, bub1}), 7);
        step(z, 0);   #1; chk("t2_release", int'({spc1, sif1, bub1}), 0);
        chk("t2_cnt", int'(cnt1), 1);

        // load-use beats a taken branch
        s = lus; s.br = 1;
        step(s, 0); #1; chk("t3_noflush", int'({fl1, spc1}), 1);
        s = z; s.br = 1;
        step(s, 0); #1; chk("t3_flush", int'(fl1), 1);

        // HLT drain and park; LU and forwarding inputs ignored once halted
        s = z; s.halt = 1;
        step(s, 0); #1; chk("t4_halt_stall", int'({spc1, sif1, bub1}), 6);
        s = lus; s.ex_rs = 3; s.mem_rd = 3; s.mem_rw = 1;
        for (int i = 0; i < DRAIN; i++) begin
            step(s, 0); #1; chk("t4_draining", int'(hlt1), 0);
        end
        step(s, 0); #1; chk("t4_halted", int'(hlt1), 1);
        chk("t4_fwd_zero", int'(fa1), 0);
        step(s, 0); #1; chk("t4_cnt_frozen", int'(cnt1), 2);

        // asynchronous reset mid-drain
        step(z, 1); step(z, 0);
        s = z; s.halt = 1;
        step(s, 0); step(z, 0);
        s = z; s.ex_rs = 3; s.mem_rd = 3; s.mem_rw = 1;
        step(s, 1); #1;
        chk("t5_async_rst", int'({fa1, spc1, sif1, bub1, hlt1}), 0);
        step(s, 0); #1; chk("t5_fwd_after", int'(fa1), 2);

        // saturation on the 2-bit counter instance
        step(z, 1);
        for (int i = 0; i < 5; i++) begin
            step(lus, 0); step(z, 0);
        end
        #1;
        chk("t6_sat2", int'(cnt2), 3);
        chk("t6_cnt16", int'(cnt1), 5);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic r;
            s.if_rs   = 4'($urandom_range(0, 3));
            s.if_rt   = 4'($urandom_range(0, 3));
            s.uses_rt = 1'($urandom_range(0, 1));
            s.halt    = ($urandom_range(0, 39) == 0);
            s.br      = ($urandom_range(0, 4) == 0);
            s.ex_rs   = 4'($urandom_range(0, 3));
            s.ex_rt   = 4'($urandom_range(0, 3));
            s.ex_rd   = 4'($urandom_range(0, 3));
            s.memrd   = ($urandom_range(0, 2) == 0);
            s.mem_rd  = 4'($urandom_range(0, 3));
            s.mem_rw  = 1'($urandom_range(0, 1));
            s.wb_rd   = 4'($urandom_range(0, 3));
            s.wb_rw   = 1'($urandom_range(0, 1));
            r = (halt_age > DRAIN + 2) || ($urandom_range(0, 199) == 0);
            step(s, r);
        end

        @(negedge clk); @(negedge clk);
        if (sb.size() != 0) chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
